// File: rtl/mac_array_ctrl_if.sv
// Command/status bundle between the command front-end and mac_array_ctrl.
// MAC_ARRAY_CTRL_PERF_EN adds the perf_cycles status counter.
interface mac_array_ctrl_if #(
    parameter int unsigned len_bw = 8
) ();
    logic              start;
    logic              mode;
    logic [len_bw-1:0] len;
    logic [2:0]        inst_w;
    logic              l0_rd;
    logic              n_rd;
    logic              ofifo_wr;
    logic              busy;
    logic              done;
`ifdef MAC_ARRAY_CTRL_PERF_EN
    logic [15:0]       perf_cycles;

    modport master (
        output start, mode, len,
        input  inst_w, l0_rd, n_rd, ofifo_wr, busy, done, perf_cycles
    );
    modport slave (
        input  start, mode, len,
        output inst_w, l0_rd, n_rd, ofifo_wr, busy, done, perf_cycles
    );
`else
    modport master (
        output start, mode, len,
        input  inst_w, l0_rd, n_rd, ofifo_wr, busy, done
    );
    modport slave (
        input  start, mode, len,
        output inst_w, l0_rd, n_rd, ofifo_wr, busy, done
    );
`endif
endinterface

// File: rtl/mac_array_ctrl.sv
// Sequencer driving the MAC array west-edge instruction bus through one WS or OS operation.
// Optional busy-cycle counter enabled by defining MAC_ARRAY_CTRL_PERF_EN.
module mac_array_ctrl #(
    parameter int unsigned row    = 8,
    parameter int unsigned col    = 8,
    parameter int unsigned len_bw = 8
) (
    input  logic             clk,
    input  logic             reset,
    mac_array_ctrl_if.slave  bus
);
    localparam int unsigned RcW  = $clog2(row + col);
    localparam int unsigned PhW  = (RcW > len_bw) ? RcW : len_bw;
    localparam int unsigned DlyW = $clog2(row + 1);

    localparam logic [PhW-1:0]  KloadLast = PhW'(row - 1);
    localparam logic [PhW-1:0]  DrainLast = PhW'(row + col - 2);
    localparam logic [PhW-1:0]  FlushLast = PhW'(row - 1);
    localparam logic [DlyW-1:0] DlyLoad   = DlyW'(row);

    typedef enum logic [2:0] {
        StIdle,
        StKload,
        StKgap,
        StExec,
        StDrain,
        StFlush,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [PhW-1:0]    ph_q, ph_d;
    logic [DlyW-1:0]   dly_q, dly_d;
    logic [len_bw-1:0] win_q, win_d;
    logic [len_bw-1:0] len_q, len_d;
    logic              mode_q, mode_d;

    logic [2:0] inst_q, inst_d;
    logic       l0_q, l0_d;
    logic       n_q, n_d;
    logic       of_q, of_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Phase sequencing: each phase counter is loaded with (duration - 1) on entry.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        mode_d  = mode_q;
        len_d   = len_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    len_d  = bus.len;
                    if (bus.len == '0) begin
                        state_d = StDone;
                    end else if (bus.mode) begin
                        state_d = StExec;
                        ph_d    = PhW'(bus.len) - PhW'(1);
                    end else begin
                        state_d = StKload;
                        ph_d    = KloadLast;
                    end
                end
            end
            StKload: begin
                if (ph_q == '0) state_d = StKgap;
                else            ph_d    = ph_q - PhW'(1);
            end
            StKgap: begin
                state_d = StExec;
                ph_d    = PhW'(len_q) - PhW'(1);
            end
            StExec: begin
                if (ph_q == '0) begin
                    state_d = StDrain;
                    ph_d    = DrainLast;
                end else begin
                    ph_d = ph_q - PhW'(1);
                end
            end
            StDrain: begin
                if (ph_q == '0) begin
                    if (mode_q) begin
                        state_d = StFlush;
                        ph_d    = FlushLast;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    ph_d = ph_q - PhW'(1);
                end
            end
            StFlush: begin
                if (ph_q == '0) state_d = StDone;
                else            ph_d    = ph_q - PhW'(1);
            end
            StDone: begin
                state_d = StIdle;
                ph_d    = '0;
            end
            default: begin
                state_d = StIdle;
                ph_d    = '0;
            end
        endcase
    end

    // WS output window: opens row cycles after the first EXEC cycle and stays open len cycles.
    always_comb begin
        dly_d = dly_q;
        win_d = win_q;
        if (state_q == StKgap) begin
            dly_d = DlyLoad;
        end else if (dly_q != '0) begin
            dly_d = dly_q - DlyW'(1);
        end
        if (dly_q == DlyW'(1)) begin
            win_d = len_q;
        end else if (win_q != '0) begin
            win_d = win_q - len_bw'(1);
        end
    end

    // Outputs decoded from the next state so the registered value lines up with the state.
    always_comb begin
        inst_d = 3'b000;
        l0_d   = 1'b0;
        n_d    = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d != StIdle);
        of_d   = (state_d == StFlush) || (win_d != '0);
        unique case (state_d)
            StKload: begin
                inst_d = 3'b001;
                l0_d   = 1'b1;
            end
            StExec: begin
                inst_d = mode_d ? 3'b110 : 3'b010;
                l0_d   = 1'b1;
                n_d    = mode_d;
            end
            StDrain: inst_d = mode_d ? 3'b100 : 3'b000;
            StFlush: inst_d = 3'b101;
            StDone:  done_d = 1'b1;
            default: inst_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ph_q    <= '0;
            dly_q   <= '0;
            win_q   <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            inst_q  <= 3'b000;
            l0_q    <= 1'b0;
            n_q     <= 1'b0;
            of_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            dly_q   <= dly_d;
            win_q   <= win_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            inst_q  <= inst_d;
            l0_q    <= l0_d;
            n_q     <= n_d;
            of_q    <= of_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.inst_w   = inst_q;
    assign bus.l0_rd    = l0_q;
    assign bus.n_rd     = n_q;
    assign bus.ofifo_wr = of_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

`ifdef MAC_ARRAY_CTRL_PERF_EN
    logic [15:0] perf_q;

    // Counts each elapsed busy cycle, so it holds the full busy length once DONE has passed.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (state_q == StIdle && bus.start) begin
            perf_q <= '0;
        end else if (busy_q && perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign bus.perf_cycles = perf_q;
`endif
endmodule
